// File: rtl/crop_sequencer_if.sv
// Bus bundle between the crop sequencer and its environment: job request/status,
// the latched window, header/pixel sub-block handshakes and the shared memory write port.
interface crop_sequencer_if;
  logic        start;
  logic [10:0] xMin, xMax, yMin, yMax;
  logic        done, err;
  logic [10:0] cx0, cx1, cy0, cy1;

  logic        hdr_start, hdr_done;
  logic [23:0] hdr_addr;
  logic        hdr_wren;
  logic [15:0] hdr_wrdata;

  logic        pix_start, pix_done;
  logic [23:0] pix_addr;
  logic        pix_wren;
  logic [15:0] pix_wrdata;

  logic [23:0] addr;
  logic        wren;
  logic [15:0] wrdata;

  modport slave (
    input  start, xMin, xMax, yMin, yMax,
    input  hdr_done, hdr_addr, hdr_wren, hdr_wrdata,
    input  pix_done, pix_addr, pix_wren, pix_wrdata,
    output done, err, cx0, cx1, cy0, cy1,
    output hdr_start, pix_start, addr, wren, wrdata
  );

  modport master (
    output start, xMin, xMax, yMin, yMax,
    output hdr_done, hdr_addr, hdr_wren, hdr_wrdata,
    output pix_done, pix_addr, pix_wren, pix_wrdata,
    input  done, err, cx0, cx1, cy0, cy1,
    input  hdr_start, pix_start, addr, wren, wrdata
  );
endinterface

// File: rtl/crop_sequencer.sv
// Crop job controller: validates/latches a window, runs header writer then pixel copier and
// muxes their write ports onto one memory port. Define CROP_CLAMP_EN to clamp oversize max bounds.
module crop_sequencer #(
  parameter int WIDTH    = 100,
  parameter int HEIGHT   = 100,
  parameter int PIX_BASE = 27,
  parameter int TIMEOUT  = 2**20
) (
  input logic             clk,
  input logic             rst_n,
  crop_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_HDR_GO, S_HDR_WAIT, S_PIX_GO, S_PIX_WAIT, S_DONE, S_ERROR
  } state_t;

  localparam logic [10:0] W_LIM    = 11'(WIDTH);
  localparam logic [10:0] W_MAX    = 11'(WIDTH - 1);
  localparam logic [10:0] H_LIM    = 11'(HEIGHT);
  localparam logic [10:0] H_MAX    = 11'(HEIGHT - 1);
  localparam logic [19:0] CNT_LAST = 20'(TIMEOUT - 1);
  localparam logic [23:0] BASE     = 24'(PIX_BASE);

  state_t      state, next_state;
  logic [19:0] cnt;
  logic [10:0] cx0_q, cx1_q, cy0_q, cy1_q;
  logic [10:0] x1_chk, y1_chk;
  logic        window_bad, accept, blanked;

  assign accept  = bus.start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  // First wait cycle still sees the previous job's done level, so it is ignored.
  assign blanked = (cnt == '0);

  assign bus.cx0 = cx0_q;
  assign bus.cx1 = cx1_q;
  assign bus.cy0 = cy0_q;
  assign bus.cy1 = cy1_q;

  always_comb begin
`ifdef CROP_CLAMP_EN
    x1_chk     = (cx1_q >= W_LIM) ? W_MAX : cx1_q;
    y1_chk     = (cy1_q >= H_LIM) ? H_MAX : cy1_q;
    window_bad = (cx0_q >= W_LIM) || (cy0_q >= H_LIM) ||
                 (cx0_q > x1_chk) || (cy0_q > y1_chk);
`else
    x1_chk     = cx1_q;
    y1_chk     = cy1_q;
    window_bad = (cx0_q > cx1_q) || (cy0_q > cy1_q) ||
                 (cx1_q >= W_LIM) || (cy1_q >= H_LIM);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      cx0_q <= '0;
      cx1_q <= '0;
      cy0_q <= '0;
      cy1_q <= '0;
    end else begin
      if (accept) begin
        cx0_q <= bus.xMin;
        cx1_q <= bus.xMax;
        cy0_q <= bus.yMin;
        cy1_q <= bus.yMax;
      end else if (state == S_CHECK) begin
        cx1_q <= x1_chk;
        cy1_q <= y1_chk;
      end

      if (state == S_HDR_GO || state == S_PIX_GO)
        cnt <= '0;
      else if (state == S_HDR_WAIT || state == S_PIX_WAIT)
        cnt <= cnt + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (accept) next_state = S_CHECK;
      S_CHECK:                 next_state = window_bad ? S_ERROR : S_HDR_GO;
      S_HDR_GO:                next_state = S_HDR_WAIT;
      S_HDR_WAIT: begin
        if (!blanked && bus.hdr_done) next_state = S_PIX_GO;
        else if (cnt == CNT_LAST)     next_state = S_ERROR;
      end
      S_PIX_GO:                next_state = S_PIX_WAIT;
      S_PIX_WAIT: begin
        if (!blanked && bus.pix_done) next_state = S_DONE;
        else if (cnt == CNT_LAST)     next_state = S_ERROR;
      end
      default:                 next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus.done      = (state == S_DONE);
    bus.err       = (state == S_ERROR);
    bus.hdr_start = (state == S_HDR_GO);
    bus.pix_start = (state == S_PIX_GO);
    bus.addr      = '0;
    bus.wren      = 1'b0;
    bus.wrdata    = '0;
    case (state)
      S_HDR_WAIT: begin
        bus.addr   = bus.hdr_addr;
        bus.wren   = bus.hdr_wren;
        bus.wrdata = bus.hdr_wrdata;
      end
      S_PIX_WAIT: begin
        bus.addr   = bus.pix_addr + BASE;
        bus.wren   = bus.pix_wren;
        bus.wrdata = bus.pix_wrdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_crop_sequencer.sv
// Self-checking bench for crop_sequencer: a job-timeline model predicts every output each cycle,
// backed by literal expectations for the directed scenarios.
module tb_crop_sequencer;
  localparam int W    = 100;
  localparam int H    = 100;
  localparam int TO   = 16;
  localparam int BASE = 27;
`ifdef CROP_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  typedef struct packed {
    logic        done, err, hs, ps, gh, gp;
    logic [10:0] x0, x1, y0, y1;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crop_sequencer_if bus ();
  crop_sequencer #(.WIDTH(W), .HEIGHT(H), .PIX_BASE(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit in_rst = 1'b1;

  // Current job timeline, in cycle numbers (cycle k = interval after the k-th rising edge).
  bit job_on = 1'b0, pend = 1'b0, bad, stale_h, stale_p;
  int s, jx0, jx1, jy0, jy1, x1c, y1c, dh, dp, h_exit, p_exit;
  int p_x0, p_x1, p_y0, p_y1, p_dh, p_dp;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic exp_t model(int k);
    exp_t m;
    int h_end, p_end;
    m = '0;
    if (in_rst || !job_on) return m;
    h_end = (dh >= 0) ? h_exit : s + 2 + TO;
    p_end = (dp >= 0) ? p_exit : h_exit + 1 + TO;
    m.x0 = 11'(jx0);
    m.y0 = 11'(jy0);
    m.x1 = 11'((k >= s + 1) ? x1c : jx1);
    m.y1 = 11'((k >= s + 1) ? y1c : jy1);
    if (bad) begin
      m.err = (k >= s + 1);
    end else begin
      m.hs = (k == s + 1);
      m.gh = (k >= s + 2) && (k < h_end);
      if (dh < 0) begin
        m.err = (k >= h_end);
      end else begin
        m.ps = (k == h_exit);
        m.gp = (k >= h_exit + 1) && (k < p_end);
        if (dp >= 0) m.done = (k >= p_exit);
        else         m.err  = (k >= p_end);
      end
    end
    return m;
  endfunction

  task automatic commit();
    job_on = 1'b1; pend = 1'b0; s = cyc;
    jx0 = p_x0; jx1 = p_x1; jy0 = p_y0; jy1 = p_y1; dh = p_dh; dp = p_dp;
    stale_h = bus.hdr_done; stale_p = bus.pix_done;
    x1c = (CLAMP && jx1 >= W) ? W - 1 : jx1;
    y1c = (CLAMP && jy1 >= H) ? H - 1 : jy1;
    if (CLAMP) bad = (jx0 >= W) || (jy0 >= H) || (jx0 > x1c) || (jy0 > y1c);
    else       bad = (jx0 > jx1) || (jy0 > jy1) || (jx1 >= W) || (jy1 >= H);
    h_exit = (dh >= 0) ? imax(s + 4, s + 2 + dh) : 1 << 28;
    p_exit = (dp >= 0) ? imax(h_exit + 3, h_exit + 1 + dp) : 1 << 28;
  endtask

  // Environment for the cycle just begun: fake sub-blocks plus random write traffic.
  task automatic drive_bus();
    bus.start      = 1'b0;
    bus.xMin       = 11'($urandom);
    bus.xMax       = 11'($urandom);
    bus.yMin       = 11'($urandom);
    bus.yMax       = 11'($urandom);
    bus.hdr_addr   = 24'($urandom);
    bus.hdr_wren   = ($urandom_range(0, 3) != 0);
    bus.hdr_wrdata = 16'($urandom);
    bus.pix_addr   = 24'($urandom);
    bus.pix_wren   = ($urandom_range(0, 3) != 0);
    bus.pix_wrdata = 16'($urandom);
    if (!job_on) begin
      bus.hdr_done = 1'b0;
      bus.pix_done = 1'b0;
    end else begin
      bus.hdr_done = (cyc < s + 3) ? stale_h : (dh >= 0 && cyc >= s + 1 + dh);
      bus.pix_done = (dh < 0 || cyc < h_exit + 2) ? stale_p : (dp >= 0 && cyc >= h_exit + dp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (pend) commit();
    @(negedge clk);
    drive_bus();
  endtask

  task automatic request(int x0, int x1, int y0, int y1, int hd, int pd);
    bus.start = 1'b1;
    bus.xMin = 11'(x0); bus.xMax = 11'(x1); bus.yMin = 11'(y0); bus.yMax = 11'(y1);
    p_x0 = x0; p_x1 = x1; p_y0 = y0; p_y1 = y1; p_dh = hd; p_dp = pd;
    pend = 1'b1;
  endtask

  task automatic run_job(int x0, int x1, int y0, int y1, int hd, int pd,
                         bit lit_valid, bit lit_done, int lit_cx1, bit inject, bit poke);
    exp_t m;
    request(x0, x1, y0, y1, hd, pd);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (inject && cyc == s + 4) begin
        bus.start = 1'b1;
        bus.xMin = 11'd1; bus.xMax = 11'd2; bus.yMin = 11'd3; bus.yMax = 11'd4;
      end
      if (poke && !bad && dh >= 0 && cyc == h_exit + 1) begin
        bus.pix_addr = 24'd0; bus.pix_wren = 1'b1;
        bus.hdr_addr = 24'h00abcd; bus.hdr_wren = 1'b1;
      end
      #2;
      if (cyc == s + 1) check("lit_hdr_start", 32'(bus.hdr_start), 32'(lit_valid));
      if (poke && !bad && dh >= 0 && cyc == h_exit + 1) begin
        check("lit_pix_addr", 32'(bus.addr), 32'd27);
        check("lit_pix_wren", 32'(bus.wren), 32'd1);
      end
      if (!bad && dh < 0 && cyc == s + 1 + TO) check("lit_timeout_early", 32'(bus.err), 32'd0);
      if (!bad && dh < 0 && cyc == s + 2 + TO) check("lit_timeout_err", 32'(bus.err), 32'd1);
      m = model(cyc);
      if (m.done || m.err) break;
    end
    repeat (2) tick();
    #2;
    check("lit_done", 32'(bus.done), 32'(lit_done));
    check("lit_err", 32'(bus.err), 32'(!lit_done));
    check("lit_cx1", 32'(bus.cx1), 32'(lit_cx1));
  endtask

  // Per-cycle comparison of every output against the timeline model.
  exp_t        cm;
  logic [23:0] c_addr;
  logic        c_wren;
  logic [15:0] c_wrdata;
  always @(negedge clk) begin
    #1;
    cm = model(cyc);
    c_addr   = cm.gh ? bus.hdr_addr   : cm.gp ? 24'(bus.pix_addr + 24'(BASE)) : 24'd0;
    c_wren   = cm.gh ? bus.hdr_wren   : cm.gp ? bus.pix_wren   : 1'b0;
    c_wrdata = cm.gh ? bus.hdr_wrdata : cm.gp ? bus.pix_wrdata : 16'd0;
    check("done",      32'(bus.done),      32'(cm.done));
    check("err",       32'(bus.err),       32'(cm.err));
    check("hdr_start", 32'(bus.hdr_start), 32'(cm.hs));
    check("pix_start", 32'(bus.pix_start), 32'(cm.ps));
    check("wren",      32'(bus.wren),      32'(c_wren));
    check("addr",      32'(bus.addr),      32'(c_addr));
    check("wrdata",    32'(bus.wrdata),    32'(c_wrdata));
    check("cx0",       32'(bus.cx0),       32'(cm.x0));
    check("cx1",       32'(bus.cx1),       32'(cm.x1));
    check("cy0",       32'(bus.cy0),       32'(cm.y0));
    check("cy1",       32'(bus.cy1),       32'(cm.y1));
  end

  initial begin
    drive_bus();
    repeat (2) tick();
    #2;
    check("lit_rst_done", 32'(bus.done), 32'd0);
    check("lit_rst_err",  32'(bus.err),  32'd0);
    check("lit_rst_wren", 32'(bus.wren), 32'd0);
    check("lit_rst_addr", 32'(bus.addr), 32'd0);
    check("lit_rst_cx1",  32'(bus.cx1),  32'd0);
    tick();
    rst_n = 1'b1;
    in_rst = 1'b0;
    tick();

    run_job(10, 19, 5, 14, 4, 5, 1'b1, 1'b1, 19, 1'b0, 1'b1);
    run_job(0, 99, 0, 99, 2, 1, 1'b1, 1'b1, 99, 1'b1, 1'b1);
    run_job(20, 10, 5, 14, -1, -1, 1'b0, 1'b0, 10, 1'b0, 1'b0);
    run_job(10, 150, 5, 14, 3, 4, CLAMP, CLAMP, CLAMP ? 99 : 150, 1'b0, 1'b1);
    run_job(0, 99, 0, 100, 3, 4, CLAMP, CLAMP, 99, 1'b0, 1'b0);
    run_job(10, 19, 5, 14, -1, -1, 1'b1, 1'b0, 19, 1'b0, 1'b0);
    run_job(10, 19, 5, 14, 3, -1, 1'b1, 1'b0, 19, 1'b0, 1'b0);

    // Asynchronous reset while the pixel copier owns the port.
    request(10, 19, 5, 14, 3, -1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (job_on && cyc == h_exit + 2) break;
    end
    bus.pix_wren = 1'b1;
    #2;
    check("lit_wren_pre_rst", 32'(bus.wren), 32'd1);
    #1;
    rst_n = 1'b0;
    in_rst = 1'b1;
    job_on = 1'b0;
    #1;
    check("lit_rst_mid_wren", 32'(bus.wren), 32'd0);
    check("lit_rst_mid_addr", 32'(bus.addr), 32'd0);
    check("lit_rst_mid_cx0",  32'(bus.cx0),  32'd0);
    check("lit_rst_mid_err",  32'(bus.err),  32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    in_rst = 1'b0;
    tick();

    run_job(5, 5, 99, 99, 5, 3, 1'b1, 1'b1, 5, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
